// File: rtl/reorder_buffer_mp.sv
// reorder_buffer_mp: in-order alloc/retire ROB with multi-port CDB capture, operand bypass and flush
module reorder_buffer_mp #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int TAG_W     = IDX_W + 1,
  parameter int DATA_W    = 32,
  parameter int OPC_W     = 12,
  parameter int RD_W      = 5,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [OPC_W-1:0]              alloc_opcode,
  input  logic [RD_W-1:0]               alloc_rd,
  input  logic                          alloc_is_branch,
  input  logic                          alloc_pred,
  output logic [TAG_W-1:0]              alloc_tag,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
  input  logic [CDB_PORTS-1:0]          cdb_taken,
  input  logic [CDB_PORTS-1:0]          cdb_exc,
  input  logic [TAG_W-1:0]              rp1_tag,
  input  logic [TAG_W-1:0]              rp2_tag,
  output logic [DATA_W-1:0]             rp1_data,
  output logic [DATA_W-1:0]             rp2_data,
  output logic                          rp1_ready,
  output logic                          rp2_ready,
  output logic                          commit_valid,
  input  logic                          commit_ready,
  output logic [OPC_W-1:0]              commit_opcode,
  output logic [RD_W-1:0]               commit_rd,
  output logic [DATA_W-1:0]             commit_data,
  output logic [TAG_W-1:0]              commit_tag,
  output logic                          commit_exc,
  output logic                          commit_mispredict,
  output logic                          flush,
  output logic [IDX_W:0]                count,
  output logic [IDX_W-1:0]              head_idx,
  output logic [IDX_W-1:0]              tail_idx,
  input  logic [IDX_W-1:0]              dbg_idx,
  output logic                          dbg_busy,
  output logic                          dbg_ready,
  output logic [RD_W-1:0]               dbg_rd,
  output logic [DATA_W-1:0]             dbg_data,
  output logic                          dbg_exc
);
  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [OPC_W-1:0]  opc;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              br;
    logic              pred;
    logic              taken;
    logic              exc;
  } ent_t;
  ent_t ent_q [DEPTH];
  ent_t ent_d [DEPTH];
  ent_t h;
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0] count_q, count_d;
  logic [IDX_W-1:0] cdb_idx [CDB_PORTS];
  logic [CDB_PORTS-1:0] cdb_hit;
  logic [TAG_W-1:0] rp_tag [2];
  logic [DATA_W-1:0] rp_data [2];
  logic [1:0] rp_ready;
  logic alloc_fire, commit_fire;
  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return t != '0 && t <= TAG_W'(DEPTH);
  endfunction
  function automatic logic [IDX_W-1:0] idx_of(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction
  assign h                 = ent_q[head_q];
  assign alloc_ready       = count_q != (IDX_W+1)'(DEPTH);
  assign alloc_tag         = TAG_W'(tail_q) + TAG_W'(1);
  assign commit_valid      = h.busy & h.ready;
  assign commit_fire       = commit_valid & commit_ready;
  assign commit_exc        = commit_valid & h.exc;
  assign commit_mispredict = commit_valid & h.br & (h.taken ^ h.pred);
  assign flush             = commit_fire & (commit_exc | commit_mispredict);
  assign alloc_fire        = alloc_valid & alloc_ready & ~flush;
  assign commit_opcode     = commit_valid ? h.opc : '0;
  assign commit_rd         = commit_valid ? h.rd : '0;
  assign commit_data       = commit_valid ? h.data : '0;
  assign commit_tag        = commit_valid ? TAG_W'(head_q) + TAG_W'(1) : '0;
  assign count             = count_q;
  assign head_idx          = head_q;
  assign tail_idx          = tail_q;
  assign dbg_busy          = ent_q[dbg_idx].busy;
  assign dbg_ready         = ent_q[dbg_idx].ready;
  assign dbg_rd            = ent_q[dbg_idx].rd;
  assign dbg_data          = ent_q[dbg_idx].data;
  assign dbg_exc           = ent_q[dbg_idx].exc;
  assign rp_tag[0]         = rp1_tag;
  assign rp_tag[1]         = rp2_tag;
  assign rp1_data          = rp_data[0];
  assign rp2_data          = rp_data[1];
  assign rp1_ready         = rp_ready[0];
  assign rp2_ready         = rp_ready[1];
  for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb
    assign cdb_idx[p] = idx_of(cdb_tag[p*TAG_W +: TAG_W]);
    assign cdb_hit[p] = cdb_valid[p] & tag_ok(cdb_tag[p*TAG_W +: TAG_W]) & ent_q[cdb_idx[p]].busy;
  end
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rp_data[r]  = '0;
      rp_ready[r] = 1'b0;
      if (tag_ok(rp_tag[r]) && ent_q[idx_of(rp_tag[r])].busy) begin
        rp_data[r]  = ent_q[idx_of(rp_tag[r])].data;
        rp_ready[r] = ent_q[idx_of(rp_tag[r])].ready;
        for (int p = 0; p < CDB_PORTS; p++)
          if (!ent_q[idx_of(rp_tag[r])].ready && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == rp_tag[r]) begin
            rp_data[r]  = cdb_data[p*DATA_W +: DATA_W];
            rp_ready[r] = 1'b1;
          end
      end
    end
  end
  always_comb begin
    ent_d = ent_q;
    if (alloc_fire)
      ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, opc: alloc_opcode, rd: alloc_rd, data: '0,
                        br: alloc_is_branch, pred: alloc_pred, taken: 1'b0, exc: 1'b0};
    for (int p = 0; p < CDB_PORTS; p++)
      if (cdb_hit[p]) begin
        ent_d[cdb_idx[p]].ready = 1'b1;
        ent_d[cdb_idx[p]].data  = cdb_data[p*DATA_W +: DATA_W];
        ent_d[cdb_idx[p]].taken = cdb_taken[p];
        ent_d[cdb_idx[p]].exc   = cdb_exc[p];
      end
    if (commit_fire) begin
      ent_d[head_q].busy  = 1'b0;
      ent_d[head_q].ready = 1'b0;
    end
    if (flush)
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].busy  = 1'b0;
        ent_d[i].ready = 1'b0;
      end
  end
  assign head_d  = flush ? '0 : head_q + IDX_W'(commit_fire);
  assign tail_d  = flush ? '0 : tail_q + IDX_W'(alloc_fire);
  assign count_d = flush ? '0 : count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer_mp.sv
// tb_reorder_buffer_mp: randomized scoreboard bench for reorder_buffer_mp against a queue-based model
module tb_reorder_buffer_mp;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alloc_valid, alloc_ready, alloc_is_branch, alloc_pred;
  logic [11:0] alloc_opcode;
  logic [4:0] alloc_rd, alloc_tag;
  logic cval [2];
  logic ctk [2];
  logic cex [2];
  logic [4:0] ctag [2];
  logic [31:0] cdat [2];
  logic [1:0] cdb_valid, cdb_taken, cdb_exc;
  logic [9:0] cdb_tag;
  logic [63:0] cdb_data;
  logic [4:0] rp1_tag, rp2_tag;
  logic [31:0] rp1_data, rp2_data;
  logic rp1_ready, rp2_ready;
  logic commit_valid, commit_ready, commit_exc, commit_mispredict, flush;
  logic [11:0] commit_opcode;
  logic [4:0] commit_rd, commit_tag;
  logic [31:0] commit_data;
  logic [4:0] count;
  logic [3:0] head_idx, tail_idx, dbg_idx;
  logic dbg_busy, dbg_ready, dbg_exc;
  logic [4:0] dbg_rd;
  logic [31:0] dbg_data;

  assign cdb_valid = {cval[1], cval[0]};
  assign cdb_tag   = {ctag[1], ctag[0]};
  assign cdb_data  = {cdat[1], cdat[0]};
  assign cdb_taken = {ctk[1], ctk[0]};
  assign cdb_exc   = {cex[1], cex[0]};

  reorder_buffer_mp dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_opcode(alloc_opcode),
    .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch), .alloc_pred(alloc_pred),
    .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_taken(cdb_taken), .cdb_exc(cdb_exc),
    .rp1_tag(rp1_tag), .rp2_tag(rp2_tag), .rp1_data(rp1_data), .rp2_data(rp2_data),
    .rp1_ready(rp1_ready), .rp2_ready(rp2_ready),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_opcode(commit_opcode),
    .commit_rd(commit_rd), .commit_data(commit_data), .commit_tag(commit_tag),
    .commit_exc(commit_exc), .commit_mispredict(commit_mispredict), .flush(flush),
    .count(count), .head_idx(head_idx), .tail_idx(tail_idx),
    .dbg_idx(dbg_idx), .dbg_busy(dbg_busy), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd),
    .dbg_data(dbg_data), .dbg_exc(dbg_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    logic [11:0] opc;
    logic [4:0] rd;
    bit br, pred, rdy, taken, exc;
    logic [31:0] data;
  } ent_t;
  typedef struct {
    int cnt, atag, head, tail;
    bit ar, cv, fl, exc, mis, r1r, r1c, r2r, r2c, dbusy, drdy;
    logic [31:0] r1d, r2d;
  } st_t;
  typedef struct {
    int tag;
    logic [11:0] opc;
    logic [4:0] rd;
    logic [31:0] data;
  } cm_t;

  ent_t rob [$];
  st_t sq [$];
  cm_t cq [$];
  int ntag = 1;
  int n_vec = 0;
  int n_err = 0;
  st_t mon_s;
  cm_t mon_c;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic int find(input int t);
    foreach (rob[i]) if (rob[i].tag == t) return i;
    return -1;
  endfunction

  task automatic lookup(input int t, output bit r, output logic [31:0] d, output bit dc);
    int i;
    i = find(t);
    r = 1'b0; d = '0; dc = 1'b1;
    if (i >= 0) begin
      if (rob[i].rdy) begin
        r = 1'b1; d = rob[i].data;
      end else begin
        dc = 1'b0;
        for (int p = 0; p < 2; p++)
          if (cval[p] && int'(ctag[p]) == t) begin
            r = 1'b1; d = cdat[p]; dc = 1'b1;
          end
      end
    end
  endtask

  // Apply one clock of stimulus: record what the DUT should show now, then advance the model.
  task automatic cycle();
    st_t s;
    cm_t c;
    ent_t e;
    int h;
    bit afire, cfire;
    s.cnt  = rob.size();
    s.ar   = s.cnt < D;
    s.atag = ntag;
    s.tail = ntag - 1;
    s.head = s.cnt > 0 ? rob[0].tag - 1 : ntag - 1;
    s.cv   = s.cnt > 0 && rob[0].rdy;
    s.exc  = s.cv && rob[0].exc;
    s.mis  = s.cv && rob[0].br && (rob[0].taken != rob[0].pred);
    s.fl   = s.cv && commit_ready && (s.exc || s.mis);
    lookup(int'(rp1_tag), s.r1r, s.r1d, s.r1c);
    lookup(int'(rp2_tag), s.r2r, s.r2d, s.r2c);
    h = find(int'(dbg_idx) + 1);
    s.dbusy = h >= 0;
    s.drdy  = h >= 0 && rob[h].rdy;
    sq.push_back(s);
    cfire = s.cv && commit_ready;
    if (cfire) begin
      c.tag = rob[0].tag; c.opc = rob[0].opc; c.rd = rob[0].rd; c.data = rob[0].data;
      cq.push_back(c);
    end
    afire = alloc_valid && s.ar;
    for (int p = 0; p < 2; p++)
      if (cval[p]) begin
        h = find(int'(ctag[p]));
        if (h >= 0) begin
          e = rob[h];
          e.rdy = 1'b1; e.data = cdat[p]; e.taken = ctk[p]; e.exc = cex[p];
          rob[h] = e;
        end
      end
    if (s.fl) begin
      rob.delete();
      ntag = 1;
    end else begin
      if (cfire) void'(rob.pop_front());
      if (afire) begin
        e.tag = ntag; e.opc = alloc_opcode; e.rd = alloc_rd; e.br = alloc_is_branch;
        e.pred = alloc_pred; e.rdy = 1'b0; e.taken = 1'b0; e.exc = 1'b0; e.data = '0;
        rob.push_back(e);
        ntag = ntag % D + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sq.size() > 0) begin
      mon_s = sq.pop_front();
      chk("count", count, mon_s.cnt);
      chk("alloc_ready", alloc_ready, mon_s.ar);
      chk("alloc_tag", alloc_tag, mon_s.atag);
      chk("head_idx", head_idx, mon_s.head);
      chk("tail_idx", tail_idx, mon_s.tail);
      chk("commit_valid", commit_valid, mon_s.cv);
      chk("flush", flush, mon_s.fl);
      chk("commit_exc", commit_exc, mon_s.exc);
      chk("commit_mispredict", commit_mispredict, mon_s.mis);
      chk("rp1_ready", rp1_ready, mon_s.r1r);
      if (mon_s.r1c) chk("rp1_data", rp1_data, mon_s.r1d);
      chk("rp2_ready", rp2_ready, mon_s.r2r);
      if (mon_s.r2c) chk("rp2_data", rp2_data, mon_s.r2d);
      chk("dbg_busy", dbg_busy, mon_s.dbusy);
      chk("dbg_ready", dbg_ready, mon_s.drdy);
      if (commit_valid && commit_ready) begin
        chk("commit_expected", cq.size() != 0, 1);
        if (cq.size() != 0) begin
          mon_c = cq.pop_front();
          chk("commit_tag", commit_tag, mon_c.tag);
          chk("commit_opcode", commit_opcode, mon_c.opc);
          chk("commit_rd", commit_rd, mon_c.rd);
          chk("commit_data", commit_data, mon_c.data);
        end
      end
    end
  end

  task automatic idle();
    alloc_valid = 1'b0; alloc_is_branch = 1'b0; alloc_pred = 1'b0;
    alloc_opcode = '0; alloc_rd = '0;
    for (int p = 0; p < 2; p++) begin
      cval[p] = 1'b0; ctag[p] = '0; cdat[p] = '0; ctk[p] = 1'b0; cex[p] = 1'b0;
    end
    rp1_tag = '0; rp2_tag = '0; commit_ready = 1'b0; dbg_idx = '0;
  endtask

  task automatic alloc(input logic [11:0] o, input logic [4:0] r, input bit b, input bit pr);
    alloc_valid = 1'b1; alloc_opcode = o; alloc_rd = r; alloc_is_branch = b; alloc_pred = pr;
  endtask

  task automatic cdb(input int p, input logic [4:0] t, input logic [31:0] d, input bit tk, input bit ex);
    cval[p] = 1'b1; ctag[p] = t; cdat[p] = d; ctk[p] = tk; cex[p] = ex;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_alloc_tag", alloc_tag, 1);
    rob.delete();
    ntag = 1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [4:0] pick_tag();
    if (rob.size() > 0 && $urandom_range(0, 3) != 0)
      return 5'(rob[$urandom_range(0, rob.size() - 1)].tag);
    return 5'($urandom_range(0, 16));
  endfunction

  task automatic rand_inputs(input int m);
    alloc_valid     = $urandom_range(0, 9) < 7;
    alloc_opcode    = 12'($urandom);
    alloc_rd        = 5'($urandom);
    alloc_is_branch = $urandom_range(0, 3) == 0;
    alloc_pred      = 1'($urandom);
    commit_ready    = m == 0 ? $urandom_range(0, 9) < 9 : m == 1 ? $urandom_range(0, 9) < 2 : $urandom_range(0, 9) < 6;
    for (int p = 0; p < 2; p++) begin
      cval[p] = 1'($urandom);
      ctag[p] = pick_tag();
      cdat[p] = $urandom;
      ctk[p]  = $urandom_range(0, 3) == 0;
      cex[p]  = $urandom_range(0, 15) == 0;
    end
    rp1_tag = pick_tag();
    rp2_tag = pick_tag();
    dbg_idx = 4'($urandom);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rp1_tag = 5'd1;
    #1;
    chk("reset_alloc_ready", alloc_ready, 1);
    chk("reset_alloc_tag", alloc_tag, 1);
    chk("reset_commit_valid", commit_valid, 0);
    chk("reset_flush", flush, 0);
    chk("reset_count", count, 0);
    chk("reset_rp1_ready", rp1_ready, 0);
    chk("reset_commit_data", commit_data, 0);
    chk("reset_commit_rd", commit_rd, 0);
    rst = 1'b0;
    rp1_tag = '0;
    @(posedge clk);
    #1;
    // two independent adds
    alloc(12'h033, 5'd10, 0, 0);
    #1 chk("first_tag", alloc_tag, 1);
    cycle();
    alloc(12'h033, 5'd15, 0, 0);
    #1 chk("second_tag", alloc_tag, 2);
    cycle();
    idle();
    #1 chk("two_alloc_count", count, 2);
    chk("two_alloc_no_commit", commit_valid, 0);
    // both results in one cycle, then in-order retire
    cdb(0, 5'd1, 32'd123, 0, 0);
    cdb(1, 5'd2, 32'd456, 0, 0);
    commit_ready = 1'b1;
    cycle();
    idle();
    commit_ready = 1'b1;
    #1 chk("retire1_rd", commit_rd, 10);
    chk("retire1_data", commit_data, 123);
    cycle();
    idle();
    commit_ready = 1'b1;
    #1 chk("retire2_rd", commit_rd, 15);
    chk("retire2_data", commit_data, 456);
    cycle();
    idle();
    #1 chk("drained_count", count, 0);
    // mispredicted beq flushes and drops a same-cycle alloc
    alloc(12'h063, 5'd1, 1, 0);
    cycle();
    idle();
    cdb(0, 5'd3, 32'd0, 1, 0);
    cycle();
    idle();
    commit_ready = 1'b1;
    alloc(12'h033, 5'd7, 0, 0);
    #1 chk("beq_mispredict", commit_mispredict, 1);
    chk("beq_flush", flush, 1);
    cycle();
    idle();
    #1 chk("flush_count", count, 0);
    chk("flush_head", head_idx, 0);
    chk("flush_tail", tail_idx, 0);
    // correctly predicted bne retires without disturbing younger entries
    alloc(12'h063, 5'd2, 1, 1);
    cycle();
    alloc(12'h033, 5'd3, 0, 0);
    cycle();
    alloc(12'h033, 5'd4, 0, 0);
    cycle();
    idle();
    cdb(1, 5'd1, 32'd77, 1, 0);
    cycle();
    idle();
    commit_ready = 1'b1;
    #1 chk("bne_commit_valid", commit_valid, 1);
    chk("bne_no_flush", flush, 0);
    cycle();
    idle();
    #1 chk("bne_retained", count, 2);
    do_reset();
    // fill to capacity
    for (int i = 0; i < D; i++) begin
      alloc(12'h033, 5'(i), 0, 0);
      cycle();
    end
    idle();
    alloc(12'h033, 5'd20, 0, 0);
    #1 chk("full_alloc_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    cycle();
    idle();
    cdb(0, 5'd1, 32'd5, 0, 0);
    cycle();
    idle();
    alloc(12'h033, 5'd20, 0, 0);
    commit_ready = 1'b1;
    #1 chk("full_commit_alloc_ready", alloc_ready, 0);
    chk("full_commit_valid", commit_valid, 1);
    cycle();
    idle();
    #1 chk("freed_alloc_ready", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 1);
    alloc(12'h033, 5'd21, 0, 0);
    cycle();
    idle();
    // same-cycle bypass on a busy, not-ready entry
    rp1_tag = 5'd3;
    rp2_tag = 5'd0;
    cdb(1, 5'd3, 32'd999, 0, 0);
    #1 chk("bypass_ready", rp1_ready, 1);
    chk("bypass_data", rp1_data, 999);
    chk("tag0_ready", rp2_ready, 0);
    cycle();
    idle();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        idle();
        do_reset();
      end
      rand_inputs((i / 150) % 3);
      cycle();
    end
    idle();
    repeat (3) cycle();
    chk("commit_queue_drained", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
